pipe_hazard_int_ctrl: RTL and testbench

PIPE_HAZARD_INT_CTRL -- requirements
Module: pipe_hazard_int_ctrl

---
 rtl/pipe_hazard_int_ctrl_pkg.sv | 30 +++
 rtl/pipe_hazard_int_ctrl_fwd_hazard_unit.sv | 57 +++++
 rtl/pipe_hazard_int_ctrl.sv | 137 +++++++++++++
 tb/tb_pipe_hazard_int_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_int_ctrl_pkg.sv
// Shared definitions for the pipeline hazard / interrupt controller:
// interrupt FSM state encoding, PC select codes and the request priority encoder.
package pipe_hazard_int_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTER   = 2'd1,
        ST_SERVICE = 2'd2,
        ST_RETURN  = 2'd3
    } int_state_t;

    localparam logic [1:0] PC_SEL_SEQ = 2'd0;  // sequential fetch or taken jump
    localparam logic [1:0] PC_SEL_VEC = 2'd1;  // interrupt vector
    localparam logic [1:0] PC_SEL_EPC = 2'd2;  // return to saved EPC

    // Lowest set request index wins; bit 0 is the highest priority source.
    function automatic logic [1:0] lowest_req(input logic [2:0] req);
        logic [1:0] idx;
        idx = 2'd0;
        if (req[0]) begin
            idx = 2'd0;
        end else if (req[1]) begin
            idx = 2'd1;
        end else if (req[2]) begin
            idx = 2'd2;
        end
        return idx;
    endfunction

endpackage

// File: rtl/pipe_hazard_int_ctrl_fwd_hazard_unit.sv
// Combinational load-use detection and operand forwarding selects for the
// two ID-stage source operands (A = rs, B = rt). EX/DM forwarding takes
// precedence over DM/WB forwarding for the same operand.
module fwd_hazard_unit
    import pipe_hazard_int_ctrl_pkg::*;
(
    input  logic [4:0] rs_id,
    input  logic [4:0] rt_id,
    input  logic       uses_rs,
    input  logic       uses_rt,
    input  logic [4:0] regfile_req_w_id_ex,
    input  logic       regfile_w_en_id_ex,
    input  logic       memtoreg_id_ex,
    input  logic [4:0] regfile_req_w_ex_dm,
    input  logic       regfile_w_en_ex_dm,
    output logic       load_use,
    output logic       redirect_regA_ex_dm,
    output logic       redirect_regA_dm_wb,
    output logic       redirect_regB_ex_dm,
    output logic       redirect_regB_dm_wb
);

    logic [4:0] src_num [2];
    logic [1:0] src_used;
    logic [1:0] hit_ex;
    logic [1:0] fwd_ex;
    logic [1:0] fwd_dm;
    logic [1:0] lu_hit;

    assign src_num[0] = rs_id;
    assign src_num[1] = rt_id;
    assign src_used   = {uses_rt, uses_rs};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            // Operand matches the EX-stage destination ($0 never forwards).
            assign hit_ex[gi] = src_used[gi] && (src_num[gi] != 5'd0)
                                && (src_num[gi] == regfile_req_w_id_ex)
                                && regfile_w_en_id_ex;
            // A load in EX cannot forward yet: that is the load-use stall.
            assign lu_hit[gi] = hit_ex[gi] & memtoreg_id_ex;
            assign fwd_ex[gi] = hit_ex[gi] & ~memtoreg_id_ex;
            // Older DM-stage result only used when EX/DM did not already win.
            assign fwd_dm[gi] = src_used[gi] && (src_num[gi] != 5'd0)
                                && (src_num[gi] == regfile_req_w_ex_dm)
                                && regfile_w_en_ex_dm && !fwd_ex[gi];
        end
    endgenerate

    assign load_use            = |lu_hit;
    assign redirect_regA_ex_dm = fwd_ex[0];
    assign redirect_regA_dm_wb = fwd_dm[0];
    assign redirect_regB_ex_dm = fwd_ex[1];
    assign redirect_regB_dm_wb = fwd_dm[1];

endmodule

// File: rtl/pipe_hazard_int_ctrl.sv
// Pipeline hazard and interrupt controller: stall/flush/forwarding control
// plus a non-nesting interrupt entry/service/return sequencer with EPC capture.
module pipe_hazard_int_ctrl
    import pipe_hazard_int_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic        uses_rs,
    input  logic        uses_rt,
    input  logic [4:0]  regfile_req_w_id_ex,
    input  logic        regfile_w_en_id_ex,
    input  logic        memtoreg_id_ex,
    input  logic [4:0]  regfile_req_w_ex_dm,
    input  logic        regfile_w_en_ex_dm,
    input  logic        jp_success,
    input  logic [31:0] jp_target,
    input  logic [2:0]  int_req,
    input  logic        ie,
    input  logic        eret_id_ex,
    input  logic [31:0] pc_id,
    input  logic        id_valid,
    input  logic [31:0] pc_if,
    output logic        load_use,
    output logic        int_nop,
    output logic        en_pc,
    output logic        en_if_id,
    output logic        flush_if_id,
    output logic [1:0]  pc_sel,
    output logic        redirect_regA_ex_dm,
    output logic        redirect_regA_dm_wb,
    output logic        redirect_regB_ex_dm,
    output logic        redirect_regB_dm_wb,
    output logic        inting,
    output logic [1:0]  int_num,
    output logic        int_ack,
    output logic [31:0] epc
);

    int_state_t  state_reg, state_next;
    logic [31:0] epc_reg, epc_next;
    logic [1:0]  int_num_reg, int_num_next;
    logic [2:0]  req_masked;

    fwd_hazard_unit u_fwd (
        .rs_id               (rs_id),
        .rt_id               (rt_id),
        .uses_rs             (uses_rs),
        .uses_rt             (uses_rt),
        .regfile_req_w_id_ex (regfile_req_w_id_ex),
        .regfile_w_en_id_ex  (regfile_w_en_id_ex),
        .memtoreg_id_ex      (memtoreg_id_ex),
        .regfile_req_w_ex_dm (regfile_req_w_ex_dm),
        .regfile_w_en_ex_dm  (regfile_w_en_ex_dm),
        .load_use            (load_use),
        .redirect_regA_ex_dm (redirect_regA_ex_dm),
        .redirect_regA_dm_wb (redirect_regA_dm_wb),
        .redirect_regB_ex_dm (redirect_regB_ex_dm),
        .redirect_regB_dm_wb (redirect_regB_dm_wb)
    );

    assign req_masked = int_req & {3{ie}};

    // A flush discards the stalled instruction, so it releases the stall.
    assign en_pc    = ~load_use | flush_if_id;
    assign en_if_id = ~load_use | flush_if_id;

    assign epc     = epc_reg;
    assign int_num = int_num_reg;

    // State, EPC and accepted-source registers; reset abandons any handler sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            epc_reg     <= 32'd0;
            int_num_reg <= 2'd0;
        end else begin
            state_reg   <= state_next;
            epc_reg     <= epc_next;
            int_num_reg <= int_num_next;
        end
    end

    // Interrupt sequencer next state and per-state pipeline controls.
    always_comb begin
        state_next   = state_reg;
        epc_next     = epc_reg;
        int_num_next = int_num_reg;
        flush_if_id  = jp_success;
        int_nop      = 1'b0;
        pc_sel       = PC_SEL_SEQ;
        int_ack      = 1'b0;
        inting       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // Do not enter while a load-use stall is holding ID.
                if ((req_masked != 3'd0) && !load_use) begin
                    state_next   = ST_ENTER;
                    int_num_next = lowest_req(req_masked);
                end
            end
            ST_ENTER: begin
                flush_if_id = 1'b1;
                int_nop     = 1'b1;
                pc_sel      = PC_SEL_VEC;
                int_ack     = 1'b1;
                // Resume at the oldest instruction not yet committed.
                if (jp_success) begin
                    epc_next = jp_target;
                end else if (id_valid) begin
                    epc_next = pc_id;
                end else begin
                    epc_next = pc_if;
                end
                state_next = ST_SERVICE;
            end
            ST_SERVICE: begin
                inting = 1'b1;
                if (eret_id_ex) begin
                    state_next = ST_RETURN;
                end
            end
            ST_RETURN: begin
                flush_if_id = 1'b1;
                int_nop     = 1'b1;
                pc_sel      = PC_SEL_EPC;
                inting      = 1'b1;
                state_next  = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pipe_hazard_int_ctrl.sv
// Self-checking bench: directed literal checks followed by randomized
// stimulus compared every cycle against a behavioural model.
module tb_pipe_hazard_int_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs_id, rt_id;
    logic        uses_rs, uses_rt;
    logic [4:0]  regfile_req_w_id_ex;
    logic        regfile_w_en_id_ex, memtoreg_id_ex;
    logic [4:0]  regfile_req_w_ex_dm;
    logic        regfile_w_en_ex_dm;
    logic        jp_success;
    logic [31:0] jp_target;
    logic [2:0]  int_req;
    logic        ie, eret_id_ex;
    logic [31:0] pc_id;
    logic        id_valid;
    logic [31:0] pc_if;
    logic        load_use, int_nop, en_pc, en_if_id, flush_if_id;
    logic [1:0]  pc_sel;
    logic        redirect_regA_ex_dm, redirect_regA_dm_wb;
    logic        redirect_regB_ex_dm, redirect_regB_dm_wb;
    logic        inting;
    logic [1:0]  int_num;
    logic        int_ack;
    logic [31:0] epc;

    int n_cmp = 0;
    int n_bad = 0;

    // model: which phase of the handler sequence we are in
    localparam int M_IDLE = 0, M_ENTERING = 1, M_IN_HANDLER = 2, M_LEAVING = 3;
    int          m_phase;
    logic [31:0] m_epc;
    logic [1:0]  m_num;

    always #5 clk = ~clk;

    pipe_hazard_int_ctrl dut (
        .clk(clk), .rst(rst),
        .rs_id(rs_id), .rt_id(rt_id), .uses_rs(uses_rs), .uses_rt(uses_rt),
        .regfile_req_w_id_ex(regfile_req_w_id_ex), .regfile_w_en_id_ex(regfile_w_en_id_ex),
        .memtoreg_id_ex(memtoreg_id_ex),
        .regfile_req_w_ex_dm(regfile_req_w_ex_dm), .regfile_w_en_ex_dm(regfile_w_en_ex_dm),
        .jp_success(jp_success), .jp_target(jp_target),
        .int_req(int_req), .ie(ie), .eret_id_ex(eret_id_ex),
        .pc_id(pc_id), .id_valid(id_valid), .pc_if(pc_if),
        .load_use(load_use), .int_nop(int_nop), .en_pc(en_pc), .en_if_id(en_if_id),
        .flush_if_id(flush_if_id), .pc_sel(pc_sel),
        .redirect_regA_ex_dm(redirect_regA_ex_dm), .redirect_regA_dm_wb(redirect_regA_dm_wb),
        .redirect_regB_ex_dm(redirect_regB_ex_dm), .redirect_regB_dm_wb(redirect_regB_dm_wb),
        .inting(inting), .int_num(int_num), .int_ack(int_ack), .epc(epc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        rs_id = 0; rt_id = 0; uses_rs = 0; uses_rt = 0;
        regfile_req_w_id_ex = 0; regfile_w_en_id_ex = 0; memtoreg_id_ex = 0;
        regfile_req_w_ex_dm = 0; regfile_w_en_ex_dm = 0;
        jp_success = 0; jp_target = 0; int_req = 0; ie = 0; eret_id_ex = 0;
        pc_id = 0; id_valid = 0; pc_if = 0;
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic src_reads(input logic used, input logic [4:0] src,
                                       input logic [4:0] dst, input logic wen);
        return used && src != 0 && src == dst && wen;
    endfunction

    function automatic logic m_load_use();
        return memtoreg_id_ex && (src_reads(uses_rs, rs_id, regfile_req_w_id_ex, regfile_w_en_id_ex) ||
                                  src_reads(uses_rt, rt_id, regfile_req_w_id_ex, regfile_w_en_id_ex));
    endfunction

    task automatic model_reset();
        m_phase = M_IDLE; m_epc = 0; m_num = 0;
    endtask

    task automatic model_advance();
        logic [2:0] pend;
        pend = int_req & {3{ie}};
        case (m_phase)
            M_IDLE: if (pend != 0 && !m_load_use()) begin
                m_phase = M_ENTERING;
                m_num = pend[0] ? 2'd0 : (pend[1] ? 2'd1 : 2'd2);
            end
            M_ENTERING: begin
                m_epc = jp_success ? jp_target : (id_valid ? pc_id : pc_if);
                m_phase = M_IN_HANDLER;
            end
            M_IN_HANDLER: if (eret_id_ex) m_phase = M_LEAVING;
            default: m_phase = M_IDLE;
        endcase
    endtask

    task automatic model_compare();
        logic lu, a_ex, b_ex, boundary, flush;
        logic [1:0] sel;
        lu   = m_load_use();
        a_ex = src_reads(uses_rs, rs_id, regfile_req_w_id_ex, regfile_w_en_id_ex) && !memtoreg_id_ex;
        b_ex = src_reads(uses_rt, rt_id, regfile_req_w_id_ex, regfile_w_en_id_ex) && !memtoreg_id_ex;
        boundary = (m_phase == M_ENTERING) || (m_phase == M_LEAVING);
        flush = boundary ? 1'b1 : jp_success;
        sel = (m_phase == M_ENTERING) ? 2'd1 : ((m_phase == M_LEAVING) ? 2'd2 : 2'd0);
        chk("load_use", load_use, lu);
        chk("en_pc", en_pc, !lu || flush);
        chk("en_if_id", en_if_id, !lu || flush);
        chk("fwdA_ex", redirect_regA_ex_dm, a_ex);
        chk("fwdB_ex", redirect_regB_ex_dm, b_ex);
        chk("fwdA_dm", redirect_regA_dm_wb,
            src_reads(uses_rs, rs_id, regfile_req_w_ex_dm, regfile_w_en_ex_dm) && !a_ex);
        chk("fwdB_dm", redirect_regB_dm_wb,
            src_reads(uses_rt, rt_id, regfile_req_w_ex_dm, regfile_w_en_ex_dm) && !b_ex);
        chk("flush", flush_if_id, flush);
        chk("int_nop", int_nop, boundary);
        chk("pc_sel", pc_sel, sel);
        chk("int_ack", int_ack, m_phase == M_ENTERING);
        chk("inting", inting, m_phase == M_IN_HANDLER || m_phase == M_LEAVING);
        chk("int_num", int_num, m_num);
        chk("epc", epc, m_epc);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        #3;
        $display("txn reset");
        chk("rst_inting", inting, 0); chk("rst_epc", epc, 0); chk("rst_num", int_num, 0);
        chk("rst_pcsel", pc_sel, 0); chk("rst_ack", int_ack, 0); chk("rst_nop", int_nop, 0);
        chk("rst_flush", flush_if_id, 0);
        tick();
        rst = 1'b0;

        // load-use on rs
        regfile_req_w_id_ex = 5; regfile_w_en_id_ex = 1; memtoreg_id_ex = 1;
        rs_id = 5; uses_rs = 1;
        #3;
        $display("txn load_use rs=5");
        chk("lu", load_use, 1); chk("lu_en_pc", en_pc, 0); chk("lu_en_if_id", en_if_id, 0);
        chk("lu_fwdA_ex", redirect_regA_ex_dm, 0); chk("lu_fwdA_dm", redirect_regA_dm_wb, 0);

        // forwarding priority on rt
        tick();
        clear_inputs();
        regfile_req_w_id_ex = 7; regfile_w_en_id_ex = 1;
        regfile_req_w_ex_dm = 7; regfile_w_en_ex_dm = 1;
        rt_id = 7; uses_rt = 1;
        #3;
        $display("txn fwd rt=7 ex+dm");
        chk("fwdB_ex_win", redirect_regB_ex_dm, 1); chk("fwdB_dm_lose", redirect_regB_dm_wb, 0);
        chk("fwd_no_lu", load_use, 0);
        rt_id = 0;
        #1;
        $display("txn fwd rt=0");
        chk("fwdB_ex_r0", redirect_regB_ex_dm, 0); chk("fwdB_dm_r0", redirect_regB_dm_wb, 0);
        rt_id = 7; regfile_req_w_id_ex = 3;
        #1;
        $display("txn fwd rt=7 dm only");
        chk("fwdB_dm_only", redirect_regB_dm_wb, 1); chk("fwdB_ex_off", redirect_regB_ex_dm, 0);

        // interrupt entry from ID pc
        tick();
        clear_inputs();
        ie = 1; int_req = 3'b110; id_valid = 1; pc_id = 32'h100;
        tick();
        #3;
        $display("txn enter req=110");
        chk("ent_ack", int_ack, 1); chk("ent_num", int_num, 1); chk("ent_pcsel", pc_sel, 1);
        chk("ent_nop", int_nop, 1); chk("ent_flush", flush_if_id, 1);
        tick();
        int_req = 3'b001;
        #3;
        $display("txn service epc=%0h", epc);
        chk("svc_epc", epc, 32'h100); chk("svc_inting", inting, 1); chk("svc_ack", int_ack, 0);
        tick();
        #3;
        $display("txn service ignores req");
        chk("nest_ack", int_ack, 0); chk("nest_num", int_num, 1); chk("nest_inting", inting, 1);
        eret_id_ex = 1;
        tick();
        eret_id_ex = 0; int_req = 0;
        #3;
        $display("txn return");
        chk("ret_pcsel", pc_sel, 2); chk("ret_nop", int_nop, 1); chk("ret_inting", inting, 1);
        chk("ret_flush", flush_if_id, 1);
        tick();
        #3;
        $display("txn back to idle");
        chk("idle_inting", inting, 0); chk("idle_pcsel", pc_sel, 0); chk("idle_nop", int_nop, 0);

        // entry with a jump resolving in the ENTER cycle
        int_req = 3'b001;
        tick();
        int_req = 0; jp_success = 1; jp_target = 32'h200;
        #3;
        chk("jp_ent_num", int_num, 0);
        tick();
        jp_success = 0;
        #3;
        $display("txn epc from jump=%0h", epc);
        chk("jp_epc", epc, 32'h200);
        eret_id_ex = 1;
        tick();
        eret_id_ex = 0;
        tick();
        // entry with empty ID: falls back to fetch PC
        int_req = 3'b100; id_valid = 0; pc_if = 32'h300;
        tick();
        int_req = 0;
        #3;
        chk("if_ent_num", int_num, 2); chk("if_ent_ack", int_ack, 1);
        tick();
        #3;
        $display("txn epc from fetch=%0h", epc);
        chk("if_epc", epc, 32'h300);

        // asynchronous reset in the middle of SERVICE
        #1;
        rst = 1'b1;
        #1;
        $display("txn async reset in service");
        chk("arst_inting", inting, 0); chk("arst_epc", epc, 0); chk("arst_num", int_num, 0);

        // randomized phase, reset still asserted so model and DUT start aligned
        clear_inputs();
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            if (!rst) model_advance();
            #1;
            rst = ($urandom_range(0, 149) == 0);
            rs_id = 5'($urandom_range(0, 3)); rt_id = 5'($urandom_range(0, 3));
            uses_rs = 1'($urandom); uses_rt = 1'($urandom);
            regfile_req_w_id_ex = 5'($urandom_range(0, 3));
            regfile_w_en_id_ex = 1'($urandom); memtoreg_id_ex = ($urandom_range(0, 3) == 0);
            regfile_req_w_ex_dm = 5'($urandom_range(0, 3)); regfile_w_en_ex_dm = 1'($urandom);
            jp_success = ($urandom_range(0, 3) == 0); jp_target = $urandom;
            int_req = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0;
            ie = ($urandom_range(0, 3) != 0);
            eret_id_ex = ($urandom_range(0, 6) == 0);
            pc_id = $urandom; id_valid = 1'($urandom); pc_if = $urandom;
            if (rst) model_reset();
            #3;
            $display("txn %0d rst=%0b req=%03b ie=%0b eret=%0b phase=%0d lu=%0b", c, rst, int_req,
                     ie, eret_id_ex, m_phase, load_use);
            model_compare();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
